// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage / data memory and the writeback stage.
// Handshake: an instruction on wb_i_* is taken on a rising edge when wb_i_valid=1 and wb_o_stall=0; while stalled, upstream holds it unchanged.
interface writeback_stage_if #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int PC_WIDTH    = 32,
    parameter int FUNCT_WIDTH = 3
);
    logic                   wb_i_valid;
    logic                   wb_i_we;
    logic [AWIDTH-1:0]      wb_i_rd_addr;
    logic [1:0]             wb_i_src;
    logic [DWIDTH-1:0]      wb_i_alu_result;
    logic [DWIDTH-1:0]      wb_i_imm;
    logic [PC_WIDTH-1:0]    wb_i_pc;
    logic [FUNCT_WIDTH-1:0] wb_i_funct3;
    logic [1:0]             wb_i_byte_off;
    logic                   wb_i_flush;
    logic                   dm_i_ack;
    logic [DWIDTH-1:0]      dm_i_rdata;
    logic                   wb_o_stall;
    logic                   wb_o_we;
    logic [AWIDTH-1:0]      wb_o_addr_rd;
    logic [DWIDTH-1:0]      wb_o_data_rd;
    logic [31:0]            wb_o_retired;
    logic                   dbg_state;

    modport master (
        output wb_i_valid, wb_i_we, wb_i_rd_addr, wb_i_src, wb_i_alu_result, wb_i_imm,
               wb_i_pc, wb_i_funct3, wb_i_byte_off, wb_i_flush, dm_i_ack, dm_i_rdata,
        input  wb_o_stall, wb_o_we, wb_o_addr_rd, wb_o_data_rd, wb_o_retired, dbg_state
    );

    modport slave (
        input  wb_i_valid, wb_i_we, wb_i_rd_addr, wb_i_src, wb_i_alu_result, wb_i_imm,
               wb_i_pc, wb_i_funct3, wb_i_byte_off, wb_i_flush, dm_i_ack, dm_i_rdata,
        output wb_o_stall, wb_o_we, wb_o_addr_rd, wb_o_data_rd, wb_o_retired, dbg_state
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects the result, waits for load data, aligns/extends loads
// and drives a registered register-file write port plus a retired-instruction counter.
module writeback_stage #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int PC_WIDTH    = 32,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic              c_clk,
    input  logic              c_rst,
    writeback_stage_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   ld_we;
    logic [AWIDTH-1:0]      ld_rd;
    logic [FUNCT_WIDTH-1:0] ld_funct3;
    logic [1:0]             ld_off;

    logic                   we_q;
    logic [AWIDTH-1:0]      addr_q;
    logic [DWIDTH-1:0]      data_q;
    logic [31:0]            retired_q;

    logic                   take_direct;
    logic                   take_load;
    logic                   load_done;
    logic [DWIDTH-1:0]      direct_data;
    logic [DWIDTH-1:0]      load_data;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;

    assign take_direct = (state == IDLE) && bus.wb_i_valid && !bus.wb_i_flush && (bus.wb_i_src != 2'b01);
    assign take_load   = (state == IDLE) && bus.wb_i_valid && !bus.wb_i_flush && (bus.wb_i_src == 2'b01);
    // Flush outranks an ack arriving in the same cycle.
    assign load_done   = (state == WAIT_LOAD) && bus.dm_i_ack && !bus.wb_i_flush;

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (take_load) state_next = WAIT_LOAD;
            WAIT_LOAD: if (bus.wb_i_flush || bus.dm_i_ack) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.wb_o_stall = (state == WAIT_LOAD);
        bus.dbg_state  = state;
    end

    always_comb begin
        case (bus.wb_i_src)
            2'b10:   direct_data = DWIDTH'(bus.wb_i_pc + PC_WIDTH'(4));
            2'b11:   direct_data = bus.wb_i_imm;
            default: direct_data = bus.wb_i_alu_result;
        endcase
    end

    always_comb begin
        byte_sel = bus.dm_i_rdata[{ld_off, 3'b000} +: 8];
        half_sel = bus.dm_i_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            3'b000:  load_data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(DWIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(DWIDTH-16){1'b0}}, half_sel};
            default: load_data = bus.dm_i_rdata;
        endcase
    end

    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            ld_we     <= 1'b0;
            ld_rd     <= '0;
            ld_funct3 <= '0;
            ld_off    <= '0;
        end else if (take_load) begin
            ld_we     <= bus.wb_i_we;
            ld_rd     <= bus.wb_i_rd_addr;
            ld_funct3 <= bus.wb_i_funct3;
            ld_off    <= bus.wb_i_byte_off;
        end
    end

    // Writes to x0 or with we=0 still retire and still move address/data.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            retired_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (take_direct) begin
                we_q      <= bus.wb_i_we && (bus.wb_i_rd_addr != '0);
                addr_q    <= bus.wb_i_rd_addr;
                data_q    <= direct_data;
                retired_q <= retired_q + 32'd1;
            end else if (load_done) begin
                we_q      <= ld_we && (ld_rd != '0);
                addr_q    <= ld_rd;
                data_q    <= load_data;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign bus.wb_o_we      = we_q;
    assign bus.wb_o_addr_rd = addr_q;
    assign bus.wb_o_data_rd = data_q;
    assign bus.wb_o_retired = retired_q;
endmodule
